// File: rtl/riscv_pkg.sv
// RV32I encodings used by the decode stage.
package riscv_pkg;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LW     = 7'b0000011;
  localparam logic [6:0] OP_SW     = 7'b0100011;
  localparam logic [6:0] OP_ALU_I  = 7'b0010011;
  localparam logic [6:0] OP_ALU    = 7'b0110011;

  localparam logic [6:0] F7_ALU_NORMAL   = 7'b0000000;
  localparam logic [6:0] F7_ALU_MODIFIED = 7'b0100000;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_SLTU    = 3'b011;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;
  localparam logic [2:0] F3_WORD    = 3'b010;

  typedef enum logic [2:0] {
    F3_BEQ  = 3'b000,
    F3_BNE  = 3'b001,
    F3_BLT  = 3'b100,
    F3_BGE  = 3'b101,
    F3_BLTU = 3'b110,
    F3_BGEU = 3'b111
  } f3_branch_t;

  typedef enum logic [3:0] {
    ALU_ADD    = 4'd0,
    ALU_SUB    = 4'd1,
    ALU_SLL    = 4'd2,
    ALU_SLT    = 4'd3,
    ALU_SLTU   = 4'd4,
    ALU_XOR    = 4'd5,
    ALU_SRL    = 4'd6,
    ALU_SRA    = 4'd7,
    ALU_OR     = 4'd8,
    ALU_AND    = 4'd9,
    ALU_PASS_B = 4'd10
  } alu_op_t;

  localparam logic [31:0] NOP_INSTR_HEX = 32'h0000_0013;
endpackage

// File: rtl/tartaruga_pkg.sv
// Project-wide datapath widths.
package tartaruga_pkg;
  typedef logic [31:0] bus32_t;
endpackage

// File: rtl/decode_stage.sv
// RV32I decode stage: combinational decode into an output register backed by a
// one-entry skid register, so upstream ready comes straight from a flop.
module decode_stage
  import riscv_pkg::*;
  import tartaruga_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        flush_i,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [31:0] in_instr_i,
  input  logic [31:0] in_pc_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [31:0] out_pc_o,
  output logic [31:0] out_imm_o,
  output logic [4:0]  out_rs1_o,
  output logic [4:0]  out_rs2_o,
  output logic [4:0]  out_rd_o,
  output logic [3:0]  out_alu_op_o,
  output logic        out_src_a_pc_o,
  output logic        out_src_b_imm_o,
  output logic        out_reg_write_o,
  output logic        out_mem_read_o,
  output logic        out_mem_write_o,
  output logic        out_branch_o,
  output logic        out_jal_o,
  output logic        out_illegal_o,
  output logic [2:0]  out_br_cond_o
);

  typedef struct packed {
    bus32_t     pc;
    bus32_t     imm;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    alu_op_t    alu_op;
    logic       src_a_pc;
    logic       src_b_imm;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic       jal;
    logic       illegal;
    logic [2:0] br_cond;
  } bundle_t;

  // Reset image of the datapath: the NOP's ADD/rd=0 fields with every flag cleared.
  localparam bundle_t NOP_BUNDLE = '0;

  function automatic alu_op_t alu_from_f3(input logic [2:0] f3, input logic modified);
    case (f3)
      F3_ADD_SUB: alu_from_f3 = modified ? ALU_SUB : ALU_ADD;
      F3_SLL:     alu_from_f3 = ALU_SLL;
      F3_SLT:     alu_from_f3 = ALU_SLT;
      F3_SLTU:    alu_from_f3 = ALU_SLTU;
      F3_XOR:     alu_from_f3 = ALU_XOR;
      F3_SRL_SRA: alu_from_f3 = modified ? ALU_SRA : ALU_SRL;
      F3_OR:      alu_from_f3 = ALU_OR;
      default:    alu_from_f3 = ALU_AND;
    endcase
  endfunction

  logic [6:0] opcode;
  logic [2:0] f3;
  logic [6:0] f7;
  bundle_t    dec;

  assign opcode = in_instr_i[6:0];
  assign f3     = in_instr_i[14:12];
  assign f7     = in_instr_i[31:25];

  always_comb begin
    dec         = '0;
    dec.pc      = in_pc_i;
    dec.rs1     = in_instr_i[19:15];
    dec.rs2     = in_instr_i[24:20];
    dec.rd      = in_instr_i[11:7];
    dec.br_cond = f3;
    dec.alu_op  = ALU_ADD;
    case (opcode)
      OP_ALU: begin
        dec.reg_write = 1'b1;
        if (f7 == F7_ALU_NORMAL) begin
          dec.alu_op = alu_from_f3(f3, 1'b0);
        end else if (f7 == F7_ALU_MODIFIED) begin
          dec.alu_op = alu_from_f3(f3, 1'b1);
          if (f3 != F3_ADD_SUB && f3 != F3_SRL_SRA) dec.illegal = 1'b1;
        end else begin
          dec.illegal = 1'b1;
        end
      end
      OP_ALU_I: begin
        dec.imm       = {{20{in_instr_i[31]}}, in_instr_i[31:20]};
        dec.src_b_imm = 1'b1;
        dec.reg_write = 1'b1;
        dec.alu_op    = alu_from_f3(f3, 1'b0);
        if (f3 == F3_SLL && f7 != F7_ALU_NORMAL) dec.illegal = 1'b1;
        if (f3 == F3_SRL_SRA) begin
          if (f7 == F7_ALU_MODIFIED) dec.alu_op = ALU_SRA;
          else if (f7 != F7_ALU_NORMAL) dec.illegal = 1'b1;
        end
      end
      OP_LUI: begin
        dec.imm       = {in_instr_i[31:12], 12'b0};
        dec.alu_op    = ALU_PASS_B;
        dec.src_b_imm = 1'b1;
        dec.reg_write = 1'b1;
      end
      OP_AUIPC: begin
        dec.imm       = {in_instr_i[31:12], 12'b0};
        dec.src_a_pc  = 1'b1;
        dec.src_b_imm = 1'b1;
        dec.reg_write = 1'b1;
      end
      OP_LW: begin
        dec.imm       = {{20{in_instr_i[31]}}, in_instr_i[31:20]};
        dec.src_b_imm = 1'b1;
        dec.mem_read  = 1'b1;
        dec.reg_write = 1'b1;
        if (f3 != F3_WORD) dec.illegal = 1'b1;
      end
      OP_SW: begin
        dec.imm       = {{20{in_instr_i[31]}}, in_instr_i[31:25], in_instr_i[11:7]};
        dec.src_b_imm = 1'b1;
        dec.mem_write = 1'b1;
        if (f3 != F3_WORD) dec.illegal = 1'b1;
      end
      OP_BRANCH: begin
        dec.imm    = {{19{in_instr_i[31]}}, in_instr_i[31], in_instr_i[7],
                      in_instr_i[30:25], in_instr_i[11:8], 1'b0};
        dec.branch = 1'b1;
        dec.alu_op = ALU_SUB;
        // funct3 010/011 are the two unassigned branch encodings
        if (f3[2:1] == 2'b01) dec.illegal = 1'b1;
      end
      OP_JAL: begin
        dec.imm       = {{11{in_instr_i[31]}}, in_instr_i[31], in_instr_i[19:12],
                         in_instr_i[20], in_instr_i[30:21], 1'b0};
        dec.jal       = 1'b1;
        dec.src_a_pc  = 1'b1;
        dec.reg_write = 1'b1;
      end
      default: dec.illegal = 1'b1;
    endcase
    if (dec.illegal) begin
      dec.reg_write = 1'b0;
      dec.mem_read  = 1'b0;
      dec.mem_write = 1'b0;
      dec.branch    = 1'b0;
      dec.jal       = 1'b0;
    end
  end

  bundle_t out_q;
  bundle_t skid_q;
  logic    out_valid_q;
  logic    skid_valid_q;
  logic    ready_q;
  logic    accept;
  logic    drain;

  assign accept = in_valid_i && ready_q && !flush_i;
  assign drain  = out_valid_q && out_ready_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      out_q        <= NOP_BUNDLE;
      skid_q       <= NOP_BUNDLE;
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      ready_q      <= 1'b1;
    end else if (flush_i) begin
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      ready_q      <= 1'b1;
    end else if (!out_valid_q || drain) begin
      // accept cannot coincide with a full skid because ready_q is low then
      if (skid_valid_q) begin
        out_q        <= skid_q;
        out_valid_q  <= 1'b1;
        skid_valid_q <= 1'b0;
        ready_q      <= 1'b1;
      end else if (accept) begin
        out_q       <= dec;
        out_valid_q <= 1'b1;
      end else begin
        out_valid_q <= 1'b0;
      end
    end else if (accept) begin
      skid_q       <= dec;
      skid_valid_q <= 1'b1;
      ready_q      <= 1'b0;
    end
  end

  assign in_ready_o      = ready_q;
  assign out_valid_o     = out_valid_q;
  assign out_pc_o        = out_q.pc;
  assign out_imm_o       = out_q.imm;
  assign out_rs1_o       = out_q.rs1;
  assign out_rs2_o       = out_q.rs2;
  assign out_rd_o        = out_q.rd;
  assign out_alu_op_o    = out_q.alu_op;
  assign out_src_a_pc_o  = out_q.src_a_pc;
  assign out_src_b_imm_o = out_q.src_b_imm;
  assign out_reg_write_o = out_q.reg_write;
  assign out_mem_read_o  = out_q.mem_read;
  assign out_mem_write_o = out_q.mem_write;
  assign out_branch_o    = out_q.branch;
  assign out_jal_o       = out_q.jal;
  assign out_illegal_o   = out_q.illegal;
  assign out_br_cond_o   = out_q.br_cond;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: a table of decode vectors plus handshake,
// flush and reset sequences.
module tb_decode_stage;
  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_imm;
  logic [4:0]  out_rs1, out_rs2, out_rd;
  logic [3:0]  out_alu_op;
  logic        out_src_a_pc, out_src_b_imm, out_reg_write, out_mem_read;
  logic        out_mem_write, out_branch, out_jal, out_illegal;
  logic [2:0]  out_br_cond;
  logic [7:0]  flags;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  decode_stage dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .in_valid_i(in_valid), .in_ready_o(in_ready),
    .in_instr_i(in_instr), .in_pc_i(in_pc),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .out_pc_o(out_pc), .out_imm_o(out_imm),
    .out_rs1_o(out_rs1), .out_rs2_o(out_rs2), .out_rd_o(out_rd),
    .out_alu_op_o(out_alu_op),
    .out_src_a_pc_o(out_src_a_pc), .out_src_b_imm_o(out_src_b_imm),
    .out_reg_write_o(out_reg_write), .out_mem_read_o(out_mem_read),
    .out_mem_write_o(out_mem_write), .out_branch_o(out_branch),
    .out_jal_o(out_jal), .out_illegal_o(out_illegal),
    .out_br_cond_o(out_br_cond)
  );

  // flag order: src_a_pc, src_b_imm, reg_write, mem_read, mem_write, branch, jal, illegal
  assign flags = {out_src_a_pc, out_src_b_imm, out_reg_write, out_mem_read,
                  out_mem_write, out_branch, out_jal, out_illegal};

  typedef struct {
    logic [31:0] instr;
    logic [31:0] imm;
    logic [3:0]  alu;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [7:0]  flg;
    logic [2:0]  br;
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    flush    = 1'b0;
    in_valid = 1'b0;
    in_instr = 32'h0000_0013;
    in_pc    = 32'h0;
  endtask

  initial begin
    //          instr          imm           alu    rs1    rs2    rd     flags         br
    vecs[0]  = '{32'h00500093, 32'h00000005, 4'd0,  5'd0,  5'd5,  5'd1,  8'b0110_0000, 3'd0};
    vecs[1]  = '{32'h402081B3, 32'h00000000, 4'd1,  5'd1,  5'd2,  5'd3,  8'b0010_0000, 3'd0};
    vecs[2]  = '{32'h022081B3, 32'h00000000, 4'd0,  5'd1,  5'd2,  5'd3,  8'b0000_0001, 3'd0};
    vecs[3]  = '{32'hFE208EE3, 32'hFFFFFFFC, 4'd1,  5'd1,  5'd2,  5'd29, 8'b0000_0100, 3'd0};
    vecs[4]  = '{32'h0020A423, 32'h00000008, 4'd0,  5'd1,  5'd2,  5'd8,  8'b0100_1000, 3'd2};
    vecs[5]  = '{32'hFFC12283, 32'hFFFFFFFC, 4'd0,  5'd2,  5'd28, 5'd5,  8'b0111_0000, 3'd2};
    vecs[6]  = '{32'h123453B7, 32'h12345000, 4'd10, 5'd8,  5'd3,  5'd7,  8'b0110_0000, 3'd5};
    vecs[7]  = '{32'h80000097, 32'h80000000, 4'd0,  5'd0,  5'd0,  5'd1,  8'b1110_0000, 3'd0};
    vecs[8]  = '{32'h008000EF, 32'h00000008, 4'd0,  5'd0,  5'd8,  5'd1,  8'b1010_0010, 3'd0};
    vecs[9]  = '{32'h40225193, 32'h00000402, 4'd7,  5'd4,  5'd2,  5'd3,  8'b0110_0000, 3'd5};
    vecs[10] = '{32'h40221193, 32'h00000402, 4'd2,  5'd4,  5'd2,  5'd3,  8'b0100_0001, 3'd1};
    vecs[11] = '{32'h0020A063, 32'h00000000, 4'd1,  5'd1,  5'd2,  5'd0,  8'b0000_0001, 3'd2};
    vecs[12] = '{32'h0000007F, 32'h00000000, 4'd0,  5'd0,  5'd0,  5'd0,  8'b0000_0001, 3'd0};
    vecs[13] = '{32'h407352B3, 32'h00000000, 4'd7,  5'd6,  5'd7,  5'd5,  8'b0010_0000, 3'd5};
    vecs[14] = '{32'h407342B3, 32'h00000000, 4'd5,  5'd6,  5'd7,  5'd5,  8'b0000_0001, 3'd4};
    vecs[15] = '{32'h00208423, 32'h00000008, 4'd0,  5'd1,  5'd2,  5'd8,  8'b0100_0001, 3'd0};

    rst = 1'b1;
    out_ready = 1'b0;
    idle_inputs();
    repeat (2) @(negedge clk);
    chk("rst out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst in_ready", {31'b0, in_ready}, 32'd1);
    chk("rst alu", {28'b0, out_alu_op}, 32'd0);
    chk("rst rd", {27'b0, out_rd}, 32'd0);
    chk("rst imm", out_imm, 32'd0);
    chk("rst flags", {24'b0, flags}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // decode table, one instruction per cycle with the sink always ready
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1;
      in_instr = vecs[i].instr;
      in_pc    = 32'h100 + 32'(4 * i);
      @(negedge clk);
      in_valid = 1'b0;
      chk($sformatf("v%0d valid", i), {31'b0, out_valid}, 32'd1);
      chk($sformatf("v%0d pc", i), out_pc, 32'h100 + 32'(4 * i));
      chk($sformatf("v%0d imm", i), out_imm, vecs[i].imm);
      chk($sformatf("v%0d alu", i), {28'b0, out_alu_op}, {28'b0, vecs[i].alu});
      chk($sformatf("v%0d regs", i), {17'b0, out_rs1, out_rs2, out_rd},
          {17'b0, vecs[i].rs1, vecs[i].rs2, vecs[i].rd});
      chk($sformatf("v%0d flags", i), {24'b0, flags}, {24'b0, vecs[i].flg});
      chk($sformatf("v%0d br", i), {29'b0, out_br_cond}, {29'b0, vecs[i].br});
    end
    @(negedge clk);
    chk("drain empty", {31'b0, out_valid}, 32'd0);

    // capacity: sink stalled, three offers, only two taken
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_instr  = 32'h00100093;
    in_pc     = 32'h400;
    @(negedge clk);
    chk("cap ready1", {31'b0, in_ready}, 32'd1);
    in_instr = 32'h00200113;
    in_pc    = 32'h404;
    @(negedge clk);
    chk("cap ready0", {31'b0, in_ready}, 32'd0);
    in_instr = 32'h00300193;
    in_pc    = 32'h408;
    @(negedge clk);
    chk("cap hold ready", {31'b0, in_ready}, 32'd0);
    chk("cap hold pc", out_pc, 32'h400);
    chk("cap hold rd", {27'b0, out_rd}, 32'd1);
    out_ready = 1'b1;
    @(negedge clk);
    chk("cap 2nd pc", out_pc, 32'h404);
    chk("cap 2nd rd", {27'b0, out_rd}, 32'd2);
    chk("cap ready back", {31'b0, in_ready}, 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    chk("cap 3rd valid", {31'b0, out_valid}, 32'd1);
    chk("cap 3rd pc", out_pc, 32'h408);
    chk("cap 3rd rd", {27'b0, out_rd}, 32'd3);
    @(negedge clk);
    chk("cap empty", {31'b0, out_valid}, 32'd0);

    // flush with both entries full and a new offer present
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_instr  = 32'h00100093;
    in_pc     = 32'h500;
    @(negedge clk);
    in_pc = 32'h504;
    @(negedge clk);
    chk("fl full", {31'b0, in_ready}, 32'd0);
    flush = 1'b1;
    in_pc = 32'h508;
    @(negedge clk);
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("fl valid", {31'b0, out_valid}, 32'd0);
    chk("fl ready", {31'b0, in_ready}, 32'd1);
    out_ready = 1'b1;
    @(negedge clk);
    chk("fl nothing", {31'b0, out_valid}, 32'd0);

    // flush while in_ready is high must still drop the offer
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_pc     = 32'h600;
    @(negedge clk);
    flush = 1'b1;
    in_pc = 32'h604;
    @(negedge clk);
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("fl1 valid", {31'b0, out_valid}, 32'd0);
    chk("fl1 ready", {31'b0, in_ready}, 32'd1);

    // reset mid-stream empties immediately; next accept decodes normally
    in_valid = 1'b1;
    in_pc    = 32'h700;
    @(negedge clk);
    in_pc = 32'h704;
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("mrst valid", {31'b0, out_valid}, 32'd0);
    chk("mrst ready", {31'b0, in_ready}, 32'd1);
    @(negedge clk);
    rst       = 1'b0;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_instr  = 32'h402081B3;
    in_pc     = 32'h800;
    @(negedge clk);
    in_valid = 1'b0;
    chk("post valid", {31'b0, out_valid}, 32'd1);
    chk("post pc", out_pc, 32'h800);
    chk("post alu", {28'b0, out_alu_op}, 32'd1);
    @(negedge clk);
    chk("post empty", {31'b0, out_valid}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
